// File: rtl/bus_pkg.sv
// Shared definitions for the strobe/acknowledge bus: initiator FSM states,
// bus widths and the default responder base addresses used by benches.
package bus_pkg;

    localparam int BUS_ADR_W = 32;
    localparam int BUS_DAT_W = 32;

    // Default constant/ID responder register addresses
    localparam logic [BUS_ADR_W-1:0] BUS_ID_BASE0 = 32'h0200_0100;
    localparam logic [BUS_ADR_W-1:0] BUS_ID_BASE1 = 32'h0200_0104;
    localparam logic [BUS_ADR_W-1:0] BUS_ID_BASE2 = 32'h0200_0108;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_initiator_if.sv
// Command port plus strobe/acknowledge bus of the bus initiator.
// master: the initiator side; slave: the command source / responder side.
interface bus_initiator_if;
    import bus_pkg::*;

    // command port
    logic                 iSTART;
    logic [BUS_ADR_W-1:0] iCMD_ADR;
    logic                 iCMD_WE;
    logic [BUS_DAT_W-1:0] iCMD_WDAT;
    logic [3:0]           iCMD_LEN;
    // responder bus
    logic                 oSTB;
    logic                 oWE;
    logic [BUS_ADR_W-1:0] oADR;
    logic [BUS_DAT_W-1:0] oDAT;
    logic [BUS_DAT_W-1:0] iDAT;
    logic                 iACK;
    // status / read return
    logic                 oRVALID;
    logic [BUS_DAT_W-1:0] oRDAT;
    logic                 oBUSY;
    logic                 oDONE;
    logic                 oERR;

    modport master (
        input  iSTART, iCMD_ADR, iCMD_WE, iCMD_WDAT, iCMD_LEN, iDAT, iACK,
        output oSTB, oWE, oADR, oDAT, oRVALID, oRDAT, oBUSY, oDONE, oERR
    );

    modport slave (
        output iSTART, iCMD_ADR, iCMD_WE, iCMD_WDAT, iCMD_LEN, iDAT, iACK,
        input  oSTB, oWE, oADR, oDAT, oRVALID, oRDAT, oBUSY, oDONE, oERR
    );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Per-beat stall counter for the bus initiator. Only built when
// BUS_TIMEOUT_EN is defined. oEXPIRE is high while the strobe has already
// gone TIMEOUT_CYCLES-1 cycles unacknowledged, i.e. during the last
// permitted cycle of the beat.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iCLR,
    input  logic iEN,
    output logic oEXPIRE
);
    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // count stalled cycles, saturating at the last permitted cycle
    always_comb begin
        cnt_d = cnt_q;
        if (iCLR)
            cnt_d = '0;
        else if (iEN && (cnt_q != LAST))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // counter register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign oEXPIRE = (cnt_q == LAST);

endmodule
`endif

// File: rtl/bus_initiator.sv
// Single-clock strobe/acknowledge bus initiator: takes a one-cycle command,
// runs a single write or a read burst of up to 16 beats on the bus, returns
// each read beat and pulses oDONE at the end.
// Optional feature macro: BUS_TIMEOUT_EN (per-beat stall timeout abort).
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_STEP      = 4
) (
    input  logic            iCLK,
    input  logic            iRST,
    bus_initiator_if.master bus
);
    localparam logic [BUS_ADR_W-1:0] ADR_INC = BUS_ADR_W'(ADDR_STEP);

    bus_state_e           state_q, state_d;
    logic [BUS_ADR_W-1:0] adr_q, adr_d;
    logic                 we_q, we_d;
    logic [BUS_DAT_W-1:0] wdat_q, wdat_d;
    logic [3:0]           beats_q, beats_d;
    logic [BUS_DAT_W-1:0] rdat_q, rdat_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic                 tmo_clr, tmo_en, tmo_expire;

    // next-state, command latch, beat sequencing and read capture
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        wdat_d   = wdat_q;
        beats_d  = beats_q;
        rdat_d   = rdat_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        tmo_clr  = 1'b0;
        tmo_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_clr = 1'b1;
                if (bus.iSTART) begin
                    adr_d   = bus.iCMD_ADR;
                    we_d    = bus.iCMD_WE;
                    wdat_d  = bus.iCMD_WDAT;
                    beats_d = bus.iCMD_WE ? 4'd0 : bus.iCMD_LEN;
                    err_d   = 1'b0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.iACK) begin
                    // an ack on the last permitted cycle still wins over expiry
                    tmo_clr = 1'b1;
                    if (!we_q) begin
                        rdat_d   = bus.iDAT;
                        rvalid_d = 1'b1;
                    end
                    if (beats_q != 4'd0) begin
                        beats_d = beats_q - 4'd1;
                        adr_d   = adr_q + ADR_INC;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expire) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            wdat_q   <= '0;
            beats_q  <= '0;
            rdat_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            wdat_q   <= wdat_d;
            beats_q  <= beats_d;
            rdat_q   <= rdat_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    bus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iCLR    (tmo_clr),
        .iEN     (tmo_en),
        .oEXPIRE (tmo_expire)
    );
`else
    // no timeout: ACCESS waits for iACK indefinitely
    logic unused_tmo;
    assign tmo_expire = 1'b0;
    assign unused_tmo = tmo_clr ^ tmo_en ^ (TIMEOUT_CYCLES > 0);
`endif

    // bus outputs are forced quiet outside ACCESS
    assign bus.oSTB    = (state_q == ST_ACCESS);
    assign bus.oWE     = (state_q == ST_ACCESS) && we_q;
    assign bus.oADR    = (state_q == ST_ACCESS) ? adr_q : '0;
    assign bus.oDAT    = ((state_q == ST_ACCESS) && we_q) ? wdat_q : '0;
    assign bus.oRVALID = rvalid_q;
    assign bus.oRDAT   = rdat_q;
    assign bus.oBUSY   = (state_q == ST_ACCESS) || (state_q == ST_RESP);
    assign bus.oDONE   = (state_q == ST_RESP);
    assign bus.oERR    = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed cases plus randomized commands checked
// against a transaction-level model (beat list, read data, end cycle, error).
// Honours BUS_TIMEOUT_EN to pick timeout or wait-forever expectations.
module tb_bus_initiator;
    import bus_pkg::*;

    localparam int TMO = 16;
`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [31:0] UNMAPPED = 32'h0200_0200;
    localparam logic [31:0] TOP_ADR  = 32'hFFFF_FFFC;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_initiator_if bif ();

    bus_initiator #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_STEP      (4)
    ) dut (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bif)
    );

    // ---------------- responder environment ----------------
    function automatic logic mapped(input logic [31:0] a);
        return (a == BUS_ID_BASE0) || (a == BUS_ID_BASE1) || (a == BUS_ID_BASE2) ||
               (a == TOP_ADR) || (a == 32'h0);
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            BUS_ID_BASE0: return 32'h0123_4567;
            BUS_ID_BASE1: return 32'h89AB_CDEF;
            BUS_ID_BASE2: return 32'hFEDC_BA98;
            TOP_ADR:      return 32'h5555_AAAA;
            32'h0:        return 32'h0BAD_F00D;
            default:      return 32'hDEAD_BEEF;
        endcase
    endfunction

    int ack_wait = 0;
    int stb_run  = 0;
    always @(posedge clk) stb_run <= (bif.oSTB && !bif.iACK) ? stb_run + 1 : 0;
    assign bif.iACK = bif.oSTB && mapped(bif.oADR) && (stb_run >= ack_wait);
    assign bif.iDAT = mapped(bif.oADR) ? rd_val(bif.oADR) : 32'hDEAD_BEEF;

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    logic        exp_err;
    int          exp_dur;
    logic [31:0] exp_rdat = '0;

    task automatic model_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             input int len, input int wait_c);
        int          nb;
        logic [31:0] a;
        beat_t       b;
        exp_beats.delete();
        exp_rd.delete();
        exp_err = 1'b0;
        exp_dur = 1;                      // first strobe cycle is cycle 1 after the start edge
        nb = we ? 1 : len + 1;
        for (int k = 0; k < nb; k++) begin
            a = adr + 32'(4 * k);
            if (mapped(a) && (!TMO_EN || wait_c <= TMO - 1)) begin
                b.we = we; b.adr = a; b.dat = we ? wdat : 32'h0;
                exp_beats.push_back(b);
                if (!we) begin
                    exp_rd.push_back(rd_val(a));
                    exp_rdat = rd_val(a);
                end
                exp_dur += wait_c + 1;
            end else begin
                exp_err = 1'b1;
                exp_dur += TMO;
                break;
            end
        end
    endtask

    // ---------------- transaction driver / monitor ----------------
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input int len, input int wait_c, input bit spam);
        beat_t       obs_beats[$];
        logic [31:0] obs_rd[$];
        logic        obs_err;
        int          done_c;
        int          stb_cycles;
        int          c;
        beat_t       b;
        model_txn(we, adr, wdat, len, wait_c);
        ack_wait = wait_c;
        bif.iCMD_ADR  = adr;
        bif.iCMD_WE   = we;
        bif.iCMD_WDAT = wdat;
        bif.iCMD_LEN  = 4'(len);
        bif.iSTART    = 1'b1;
        @(posedge clk); #1;
        bif.iSTART = 1'b0;
        done_c = -1; stb_cycles = 0; obs_err = 1'b0; c = 1;
        while (c < 400) begin
            if (bif.oSTB) stb_cycles++;
            if (bif.oSTB && bif.iACK) begin
                b.we = bif.oWE; b.adr = bif.oADR; b.dat = bif.oDAT;
                obs_beats.push_back(b);
            end
            if (bif.oRVALID) obs_rd.push_back(bif.oRDAT);
            if (bif.oDONE) begin
                done_c  = c;
                obs_err = bif.oERR;
                break;
            end
            if (spam) begin
                // conflicting command while busy; must be dropped
                bif.iSTART    = c[0];
                bif.iCMD_ADR  = BUS_ID_BASE2;
                bif.iCMD_WE   = 1'b1;
                bif.iCMD_WDAT = 32'h1234_5678;
            end
            @(posedge clk); #1;
            c++;
        end
        bif.iSTART = spam;                // a start during oDONE is ignored too
        chk("done_cycle", 64'(done_c), 64'(exp_dur));
        chk("err", {63'b0, obs_err}, {63'b0, exp_err});
        chk("stb_cycles", 64'(stb_cycles), 64'(exp_dur - 1));
        chk("n_beats", 64'(obs_beats.size()), 64'(exp_beats.size()));
        if (obs_beats.size() == exp_beats.size())
            foreach (exp_beats[i]) begin
                chk("beat_adr", {32'b0, obs_beats[i].adr}, {32'b0, exp_beats[i].adr});
                chk("beat_we_dat", {31'b0, obs_beats[i].we, obs_beats[i].dat},
                                   {31'b0, exp_beats[i].we, exp_beats[i].dat});
            end
        chk("n_rvalid", 64'(obs_rd.size()), 64'(exp_rd.size()));
        if (obs_rd.size() == exp_rd.size())
            foreach (exp_rd[i]) chk("rdat_beat", {32'b0, obs_rd[i]}, {32'b0, exp_rd[i]});
        // mandatory idle cycle after oDONE
        @(posedge clk); #1;
        bif.iSTART = 1'b0;
        chk("idle_busy", {63'b0, bif.oBUSY}, 64'd0);
        chk("idle_stb", {63'b0, bif.oSTB}, 64'd0);
        chk("idle_done", {63'b0, bif.oDONE}, 64'd0);
        chk("idle_rvalid", {63'b0, bif.oRVALID}, 64'd0);
        chk("rdat_hold", {32'b0, bif.oRDAT}, {32'b0, exp_rdat});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] starts [5];
        int          maxlen [5];
        int          idx, len, r, wt;
        logic        we;
        int          stb_cnt, done_cnt;

        starts = '{BUS_ID_BASE0, BUS_ID_BASE1, BUS_ID_BASE2, TOP_ADR, UNMAPPED};
        maxlen = '{2, 1, 0, 1, 0};

        bif.iSTART = 1'b0; bif.iCMD_ADR = '0; bif.iCMD_WE = 1'b0;
        bif.iCMD_WDAT = '0; bif.iCMD_LEN = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stb",    {63'b0, bif.oSTB},    64'd0);
        chk("rst_we",     {63'b0, bif.oWE},     64'd0);
        chk("rst_adr",    {32'b0, bif.oADR},    64'd0);
        chk("rst_dat",    {32'b0, bif.oDAT},    64'd0);
        chk("rst_rvalid", {63'b0, bif.oRVALID}, 64'd0);
        chk("rst_rdat",   {32'b0, bif.oRDAT},   64'd0);
        chk("rst_busy",   {63'b0, bif.oBUSY},   64'd0);
        chk("rst_done",   {63'b0, bif.oDONE},   64'd0);
        chk("rst_err",    {63'b0, bif.oERR},    64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single read, burst read, single write
        run_txn(1'b0, BUS_ID_BASE0, 32'h0, 0, 0, 1'b0);
        run_txn(1'b0, BUS_ID_BASE0, 32'h0, 2, 0, 1'b0);
        run_txn(1'b1, BUS_ID_BASE1, 32'hA5A5_A5A5, 0, 0, 1'b0);

        // stalled read of an unmapped address
        if (TMO_EN) begin
            run_txn(1'b0, UNMAPPED, 32'h0, 0, 0, 1'b0);
        end else begin
            bif.iCMD_ADR = UNMAPPED; bif.iCMD_WE = 1'b0; bif.iCMD_LEN = 4'd0;
            bif.iSTART = 1'b1;
            @(posedge clk); #1;
            bif.iSTART = 1'b0;
            stb_cnt = 0; done_cnt = 0;
            for (int i = 0; i < 40; i++) begin
                if (bif.oSTB) stb_cnt++;
                if (bif.oDONE) done_cnt++;
                @(posedge clk); #1;
            end
            chk("hang_stb_cycles", 64'(stb_cnt), 64'd40);
            chk("hang_no_done", 64'(done_cnt), 64'd0);
            rst_n = 1'b0; #1;
            chk("hang_rst_stb", {63'b0, bif.oSTB}, 64'd0);
            exp_rdat = '0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end

        // ack on the last permitted strobe cycle
        run_txn(1'b0, BUS_ID_BASE0, 32'h0, 0, TMO - 1, 1'b0);

        // reset in the middle of a burst, after beat 1 was acknowledged
        ack_wait = 0;
        bif.iCMD_ADR = BUS_ID_BASE0; bif.iCMD_WE = 1'b0; bif.iCMD_LEN = 4'd2;
        bif.iSTART = 1'b1;
        @(posedge clk); #1;
        bif.iSTART = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_burst_adr", {32'b0, bif.oADR}, {32'b0, BUS_ID_BASE2});
        rst_n = 1'b0; #1;
        chk("mid_rst_stb",    {63'b0, bif.oSTB},    64'd0);
        chk("mid_rst_busy",   {63'b0, bif.oBUSY},   64'd0);
        chk("mid_rst_rvalid", {63'b0, bif.oRVALID}, 64'd0);
        chk("mid_rst_rdat",   {32'b0, bif.oRDAT},   64'd0);
        exp_rdat = '0;
        @(posedge clk); #1;
        chk("mid_rst_done", {63'b0, bif.oDONE}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", {63'b0, bif.oDONE}, 64'd0);
        chk("post_rst_stb",  {63'b0, bif.oSTB},  64'd0);
        run_txn(1'b0, BUS_ID_BASE2, 32'h0, 0, 0, 1'b0);

        // iSTART pulsed while busy
        run_txn(1'b0, BUS_ID_BASE0, 32'h0, 1, 1, 1'b1);

        // address wrap at the top of the space
        run_txn(1'b0, TOP_ADR, 32'h0, 1, 0, 1'b0);

        // randomized commands
        for (int n = 0; n < 30; n++) begin
            we  = 1'($urandom % 2);
            idx = int'($urandom % 5);
            if (!TMO_EN && idx == 4) idx = 0;
            len = TMO_EN ? int'($urandom % 4) : int'($urandom_range(0, maxlen[idx]));
            r   = int'($urandom % 8);
            if (r < 6)       wt = r % 3;
            else if (r == 6) wt = TMO - 1;
            else             wt = TMO_EN ? TMO : TMO - 1;
            run_txn(we, starts[idx], $urandom, len, wt, ($urandom % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
